rr_mux_4x1_4bit: RTL and testbench

Four-source, 4-bit gathering multiplexer: the return path for the 1-to-4 demux fabric. It arbitrates round-robin among four valid/ready input channels (a, b, c, d) and registers the winner onto one output channel. The output is tagged with a 2-bit source index whose encoding matches the demux `sel` (a=0, b=1, c=2, d=3), so the downstream logic can route responses back. Throughput is one word per cycle, with a single output register stage.

---
 rtl/rr_mux_4x1_4bit.sv | 102 ++++++++++
 tb/tb_rr_mux_4x1_4bit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4x1_4bit.sv
// Four-source round-robin gathering mux with a single registered output slot.
// Build option: define FIXED_PRIORITY_EN to make source a always win (scan order 0,1,2,3).
module rr_mux_4x1_4bit #(
  parameter int WIDTH = 4,
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [N_SRC-1:0] in_valid,
  output logic [N_SRC-1:0] in_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  // Handshake: a word moves on any channel only in a cycle where valid & ready are
  // both high at the rising edge; ready never depends on the same channel's data.
  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             load_ok;
  logic [N_SRC-1:0] gnt_oh;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] gnt_data;

  // Slot is free, or its current word leaves this same edge.
  assign load_ok = ~valid_q | out_ready;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
`ifdef FIXED_PRIORITY_EN
      idx = 2'(k);
`else
      idx = ptr_q + 2'(k + 1);
`endif
      if (!found && in_valid[idx]) begin
        found       = 1'b1;
        gnt_idx     = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  assign in_ready = (rst_n && load_ok) ? gnt_oh : '0;

  always_comb begin
    gnt_data = '0;
    case (gnt_idx)
      2'd0:    gnt_data = a;
      2'd1:    gnt_data = b;
      2'd2:    gnt_data = c;
      default: gnt_data = d;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (|in_ready) begin
      out_d   = gnt_data;
      sel_d   = gnt_idx;
      valid_d = 1'b1;
      ptr_d   = gnt_idx;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd3;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_4x1_4bit.sv
// Scoreboard bench for rr_mux_4x1_4bit: directed scenarios then random traffic
// against a queue-based reference model; a separate monitor checks delivered words.
module tb_rr_mux_4x1_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b, c, d;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] out;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_q[$];
  int         m_ptr  = 3;
  bit         m_full = 1'b0;

  always #5 clk = ~clk;

  rr_mux_4x1_4bit #(.WIDTH(4), .N_SRC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting source after the last grant, wrapping.
  function automatic int winner(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      int s;
`ifdef FIXED_PRIORITY_EN
      s = k - 1;
`else
      s = (last + k) % 4;
`endif
      if (v[s]) return s;
    end
    return -1;
  endfunction

  task automatic step(input logic [3:0] v, input logic [3:0] da, input logic [3:0] db,
                      input logic [3:0] dc, input logic [3:0] dd, input logic ordy);
    int         g;
    logic [3:0] exp_rdy;
    logic [3:0] data [4];
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = v;
    a         = da;
    b         = db;
    c         = dc;
    d         = dd;
    out_ready = ordy;
    data      = '{da, db, dc, dd};
    #1;
    g = (!m_full || ordy) ? winner(v, m_ptr) : -1;
    exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
    check("in_ready", {4'b0, in_ready}, {4'b0, exp_rdy});
    if (g >= 0) exp_q.push_back({2'(g), data[g]});
    @(posedge clk);
    if (g >= 0) begin
      m_ptr  = g;
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (cycles) begin
      #1;
      check("rst_in_ready", {4'b0, in_ready}, 8'h00);
      @(posedge clk);
      #1;
      check("rst_out_valid", {7'b0, out_valid}, 8'h00);
      check("rst_out", {4'b0, out}, 8'h00);
      check("rst_out_sel", {6'b0, out_sel}, 8'h00);
      @(negedge clk);
    end
    exp_q.delete();
    m_ptr     = 3;
    m_full    = 1'b0;
    in_valid  = 4'b0000;
    rst_n     = 1'b1;
  endtask

  // Monitor: every output handshake must deliver the oldest expected word.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {2'b0, out_sel, out}, 8'hFF);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {2'b0, out_sel, out}, {2'b0, e});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = '0; a = '0; b = '0; c = '0; d = '0; out_ready = 1'b0;

    do_reset(2);
    step(4'b0001, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    repeat (8) step(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    step(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1);
    repeat (3) begin
      step(4'b0010, 4'h0, 4'h6, 4'h0, 4'h0, 1'b0);
      #1;
      check("stall_out", {2'b0, out_sel, out}, {2'b0, 2'd2, 4'hA});
    end
    step(4'b0010, 4'h0, 4'h6, 4'h0, 4'h0, 1'b1);
    #1;
    check("no_bubble", {3'b0, out_valid, out}, {3'b0, 1'b1, 4'h6});
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    step(4'b1000, 4'h0, 4'h0, 4'h0, 4'h7, 1'b1);
    step(4'b1001, 4'h8, 4'h0, 4'h0, 4'h9, 1'b1);
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    step(4'b0010, 4'h0, 4'h9, 4'h0, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    #1;
    check("drain_keep", {1'b0, out_valid, out_sel, out}, {1'b0, 1'b0, 2'd1, 4'h9});

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1);
      end else begin
        step(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    repeat (4) step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
